fp_add_align: RTL and testbench

//  Front end of the single-precision FP add/sub pipeline.
//  - Unpacks two IEEE-754 binary32 operands.
//  - Orders them by magnitude and right-aligns the smaller significand.
//  - Presents the two 24-bit significands to the 24-bit carry-lookahead adder

---
 rtl/fp_add_align_if.sv | 49 ++++
 rtl/fp_add_align.sv | 187 ++++++++++++++++++
 tb/tb_fp_add_align.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_align_if.sv
//------------------------------------------------------------------------------
// Module   : fp_add_align_if
// Brief    : Operand-in / aligned-fields-out stream bundle for fp_add_align.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fp_add_align_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int WORD_W = EXP_W + MAN_W + 1;
   localparam int SIG_W  = MAN_W + 1;

   // operand pair stream
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_a;
   logic [WORD_W-1:0] in_b;
   logic              in_sub;

   // aligned result stream
   logic              out_valid;
   logic              out_ready;
   logic [SIG_W-1:0]  out_x;
   logic [SIG_W-1:0]  out_y;
   logic [2:0]        out_grs;
   logic [EXP_W-1:0]  out_exp;
   logic              out_sign;
   logic              out_eff_sub;
   logic              out_bypass;
   logic [WORD_W-1:0] out_bypass_val;

   // producer of operands / consumer of results
   modport master (
      output in_valid, in_a, in_b, in_sub, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_grs, out_exp,
             out_sign, out_eff_sub, out_bypass, out_bypass_val
   );

   // the alignment block itself
   modport slave (
      input  in_valid, in_a, in_b, in_sub, out_ready,
      output in_ready, out_valid, out_x, out_y, out_grs, out_exp,
             out_sign, out_eff_sub, out_bypass, out_bypass_val
   );
endinterface

`default_nettype wire

// File: rtl/fp_add_align.sv
//------------------------------------------------------------------------------
// Module   : fp_add_align
// Brief    : FP add/sub front end. Unpacks two binary32 operands, orders them
//            by magnitude and right-aligns the smaller significand with
//            guard/round/sticky. Two-stage valid/ready pipeline.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_add_align #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic         clk,
   input  logic         rst_n,
   fp_add_align_if.slave bus
);
   localparam int WORD_W = EXP_W + MAN_W + 1;
   localparam int SIG_W  = MAN_W + 1;
   localparam int EXT_W  = SIG_W + 3;
   // shift distance from which the whole significand lands in sticky
   localparam logic [EXP_W-1:0] SHIFT_ALL = EXP_W'(SIG_W + 2);
   localparam logic [WORD_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // ---------------- stage 1 combinational: unpack, compare, swap ----------
   logic [EXP_W-1:0] w_exp_a, w_exp_b, w_ea, w_eb, w_d;
   logic [SIG_W-1:0] w_sig_a, w_sig_b;
   logic             w_sign_a, w_sign_b, w_a_big, w_eq_mag;
   logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b;
   logic             w_bypass;
   logic [WORD_W-1:0] w_bypass_val;
   logic             w_s1_en, w_s2_en;

   assign w_exp_a  = bus.in_a[WORD_W-2 -: EXP_W];
   assign w_exp_b  = bus.in_b[WORD_W-2 -: EXP_W];
   assign w_sign_a = bus.in_a[WORD_W-1];
   assign w_sign_b = bus.in_b[WORD_W-1] ^ bus.in_sub;
   // denormals (and zero) have no hidden bit and behave as exponent 1
   assign w_ea     = (w_exp_a == '0) ? EXP_W'(1) : w_exp_a;
   assign w_eb     = (w_exp_b == '0) ? EXP_W'(1) : w_exp_b;
   assign w_sig_a  = {|w_exp_a, bus.in_a[MAN_W-1:0]};
   assign w_sig_b  = {|w_exp_b, bus.in_b[MAN_W-1:0]};
   assign w_a_big  = (w_ea > w_eb) || ((w_ea == w_eb) && (w_sig_a >= w_sig_b));
   assign w_eq_mag = (w_ea == w_eb) && (w_sig_a == w_sig_b);
   assign w_d      = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);

   assign w_nan_a  = (&w_exp_a) && (|bus.in_a[MAN_W-1:0]);
   assign w_nan_b  = (&w_exp_b) && (|bus.in_b[MAN_W-1:0]);
   assign w_inf_a  = (&w_exp_a) && !(|bus.in_a[MAN_W-1:0]);
   assign w_inf_b  = (&w_exp_b) && !(|bus.in_b[MAN_W-1:0]);

   // special-case result selection; NaN and inf-inf dominate single infinities
   always_comb begin
      w_bypass     = 1'b1;
      w_bypass_val = '0;
      if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sign_a != w_sign_b))) begin
         w_bypass_val = QNAN;
      end else if (w_inf_a) begin
         w_bypass_val = {w_sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_inf_b) begin
         w_bypass_val = {w_sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else begin
         w_bypass = 1'b0;
      end
   end

   // ---------------- handshake ---------------------------------------------
   logic r1_valid, r2_valid;

   assign w_s2_en      = ~r2_valid | bus.out_ready;
   assign w_s1_en      = ~r1_valid | w_s2_en;
   assign bus.in_ready = w_s1_en;

   // ---------------- stage 1 registers --------------------------------------
   logic [SIG_W-1:0]  r1_x, r1_small;
   logic [EXP_W-1:0]  r1_exp, r1_d;
   logic              r1_sign, r1_eff_sub, r1_bypass;
   logic [WORD_W-1:0] r1_bypass_val;

   // capture the ordered operand pair; bypass pairs carry zeroed data fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid      <= 1'b0;
         r1_x          <= '0;
         r1_small      <= '0;
         r1_exp        <= '0;
         r1_d          <= '0;
         r1_sign       <= 1'b0;
         r1_eff_sub    <= 1'b0;
         r1_bypass     <= 1'b0;
         r1_bypass_val <= '0;
      end else if (w_s1_en) begin
         r1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r1_bypass     <= w_bypass;
            r1_bypass_val <= w_bypass_val;
            if (w_bypass) begin
               r1_x       <= '0;
               r1_small   <= '0;
               r1_exp     <= '0;
               r1_d       <= '0;
               r1_sign    <= 1'b0;
               r1_eff_sub <= 1'b0;
            end else begin
               r1_x       <= w_a_big ? w_sig_a : w_sig_b;
               r1_small   <= w_a_big ? w_sig_b : w_sig_a;
               r1_exp     <= w_a_big ? w_ea : w_eb;
               r1_d       <= w_d;
               r1_eff_sub <= w_sign_a ^ w_sign_b;
               // exact cancellation yields +0
               r1_sign    <= ((w_sign_a != w_sign_b) && w_eq_mag) ? 1'b0
                             : (w_a_big ? w_sign_a : w_sign_b);
            end
         end
      end
   end

   // ---------------- stage 2 combinational: barrel shift + sticky ------------
   logic [EXT_W-1:0] w_ext, w_shifted, w_lost_mask;
   logic [SIG_W-1:0] w_y;
   logic [2:0]       w_grs;

   assign w_ext = {r1_small, 3'b000};

   // right-align the smaller significand; everything past round folds into sticky
   always_comb begin
      w_shifted   = '0;
      w_lost_mask = '0;
      w_y         = '0;
      w_grs       = 3'b000;
      if (r1_d >= SHIFT_ALL) begin
         w_grs = {2'b00, |r1_small};
      end else begin
         w_shifted   = w_ext >> r1_d;
         w_lost_mask = ~({EXT_W{1'b1}} << r1_d);
         w_y         = w_shifted[EXT_W-1:3];
         w_grs       = {w_shifted[2], w_shifted[1], w_shifted[0] | (|(w_ext & w_lost_mask))};
      end
   end

   // ---------------- stage 2 registers (drive the outputs) -------------------
   logic [SIG_W-1:0]  r2_x, r2_y;
   logic [2:0]        r2_grs;
   logic [EXP_W-1:0]  r2_exp;
   logic              r2_sign, r2_eff_sub, r2_bypass;
   logic [WORD_W-1:0] r2_bypass_val;

   // output register; holds while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_valid      <= 1'b0;
         r2_x          <= '0;
         r2_y          <= '0;
         r2_grs        <= '0;
         r2_exp        <= '0;
         r2_sign       <= 1'b0;
         r2_eff_sub    <= 1'b0;
         r2_bypass     <= 1'b0;
         r2_bypass_val <= '0;
      end else if (w_s2_en) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_x          <= r1_x;
            r2_y          <= w_y;
            r2_grs        <= w_grs;
            r2_exp        <= r1_exp;
            r2_sign       <= r1_sign;
            r2_eff_sub    <= r1_eff_sub;
            r2_bypass     <= r1_bypass;
            r2_bypass_val <= r1_bypass_val;
         end
      end
   end

   assign bus.out_valid      = r2_valid;
   assign bus.out_x          = r2_x;
   assign bus.out_y          = r2_y;
   assign bus.out_grs        = r2_grs;
   assign bus.out_exp        = r2_exp;
   assign bus.out_sign       = r2_sign;
   assign bus.out_eff_sub    = r2_eff_sub;
   assign bus.out_bypass     = r2_bypass;
   assign bus.out_bypass_val = r2_bypass_val;

endmodule

`default_nettype wire

// File: tb/tb_fp_add_align.sv
//------------------------------------------------------------------------------
// Module   : tb_fp_add_align
// Brief    : Self-checking bench for fp_add_align with a behavioural model,
//            directed corner cases and randomized operand/handshake traffic.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fp_add_align;

   typedef struct packed {
      logic [23:0] x;
      logic [23:0] y;
      logic [2:0]  grs;
      logic [7:0]  e;
      logic        sign;
      logic        eff_sub;
      logic        bypass;
      logic [31:0] bv;
   } res_t;

   logic clk;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   res_t        exp_q[$];
   string       chk_name[$];
   logic [95:0] chk_act[$];
   logic [95:0] chk_exp[$];
   logic        held_v = 1'b0;
   res_t        held;

   fp_add_align_if bus ();

   fp_add_align dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural reference: real-number style alignment on a wide integer
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      res_t        r;
      int          ea, eb, d;
      logic [63:0] ma, mb, mbig, msmall, val, sh;
      logic        sa, sb, a_big, lost;
      logic        nan_a, nan_b, inf_a, inf_b;
      r     = '0;
      sa    = a[31];
      sb    = b[31] ^ sub;
      nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
         r.bypass = 1'b1;
         r.bv     = 32'h7FC00000;
         return r;
      end
      if (inf_a || inf_b) begin
         r.bypass = 1'b1;
         r.bv     = {(inf_a ? sa : sb), 31'h7F800000};
         return r;
      end
      ea    = (a[30:23] == 0) ? 1 : int'(a[30:23]);
      eb    = (b[30:23] == 0) ? 1 : int'(b[30:23]);
      ma    = ((a[30:23] == 0) ? 64'd0 : 64'd8388608) + 64'(a[22:0]);
      mb    = ((b[30:23] == 0) ? 64'd0 : 64'd8388608) + 64'(b[22:0]);
      a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
      d      = a_big ? ea - eb : eb - ea;
      mbig   = a_big ? ma : mb;
      msmall = a_big ? mb : ma;
      val    = msmall << 40;
      if (d >= 64) begin
         sh   = 64'd0;
         lost = (msmall != 0);
      end else begin
         sh   = val >> d;
         lost = ((sh << d) != val);
      end
      r.x       = mbig[23:0];
      r.y       = sh[63:40];
      r.grs     = {sh[39], sh[38], (sh[37:0] != 0) || lost};
      r.e       = 8'(a_big ? ea : eb);
      r.eff_sub = sa ^ sb;
      r.sign    = ((sa != sb) && (ea == eb) && (ma == mb)) ? 1'b0 : (a_big ? sa : sb);
      return r;
   endfunction

   function automatic res_t dut_res();
      return {bus.out_x, bus.out_y, bus.out_grs, bus.out_exp, bus.out_sign,
              bus.out_eff_sub, bus.out_bypass, bus.out_bypass_val};
   endfunction

   // queue a check to be tallied by the compare process
   task automatic post(input string n, input logic [95:0] act, input logic [95:0] req);
      chk_name.push_back(n);
      chk_act.push_back(act);
      chk_exp.push_back(req);
   endtask

   task automatic tally(input string n, input logic [95:0] act, input logic [95:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %h required %h", n, act, req);
      end
   endtask

   // compare process: posted checks, output stability and scoreboard
   always @(negedge clk) begin
      res_t e, r;
      while (chk_name.size() != 0) begin
         tally(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
      end
      if (!rst_n) begin
         exp_q.delete();
         held_v = 1'b0;
      end else begin
         r = dut_res();
         if (held_v) tally("hold_stable", {bus.out_valid, r}, {1'b1, held});
         if (bus.out_valid && bus.out_ready) begin
            tally("pending_on_out", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               tally("scoreboard", r, e);
            end
         end
         held_v = bus.out_valid && !bus.out_ready;
         held   = r;
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_sub));
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sub   = sub;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      post("send_accept", 96'(bus.in_ready), 96'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] rand_fp();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 9))
         0:       w[30:0]  = '0;
         1:       w[30:23] = '0;
         2:       begin w[30:23] = 8'hFF; w[22:0] = '0; end
         3:       w[30:23] = 8'hFF;
         default: w[30:23] = 8'($urandom_range(100, 150));
      endcase
      return w;
   endfunction

   logic [31:0] pa[3];
   logic [31:0] pb[3];

   initial begin
      res_t        m;
      int          acc_n, k, wait_n, ex;
      logic        acc;
      logic [31:0] ra, rb;

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b0;
      pa[0] = 32'h3F800000; pb[0] = 32'h40000000;
      pa[1] = 32'h40400000; pb[1] = 32'h3F800000;
      pa[2] = 32'hC0A00000; pb[2] = 32'h3E800000;

      repeat (3) @(posedge clk);
      #1;
      post("rst_out_valid", 96'(bus.out_valid), 96'd0);
      post("rst_in_ready", 96'(bus.in_ready), 96'd1);
      post("rst_out_fields", dut_res(), 96'd0);

      // hand-computed values that pin the model
      m = model(32'h3F800000, 32'h3F800000, 1'b0);
      post("pin_t1", m, {24'h800000, 24'h800000, 3'b000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0});
      m = model(32'h3F800000, 32'h33800000, 1'b0);
      post("pin_d24", m, {24'h800000, 24'h000000, 3'b100, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0});
      m = model(32'h3F800000, 32'h33000000, 1'b0);
      post("pin_d25", m, {24'h800000, 24'h000000, 3'b010, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0});
      m = model(32'h3FC00000, 32'h40400000, 1'b1);
      post("pin_t3", m, {24'hC00000, 24'h600000, 3'b000, 8'd128, 1'b1, 1'b1, 1'b0, 32'h0});
      m = model(32'h7F800000, 32'h7F800000, 1'b1);
      post("pin_infinf", m, {62'h0, 1'b1, 32'h7FC00000});
      m = model(32'h7F800000, 32'h3F800000, 1'b1);
      post("pin_inf", m, {62'h0, 1'b1, 32'h7F800000});

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

      // latency and directed values
      send(32'h3F800000, 32'h3F800000, 1'b0);
      post("t1_lat1", 96'(bus.out_valid), 96'd0);
      @(posedge clk);
      #1;
      post("t1_lat2", 96'(bus.out_valid), 96'd1);
      post("t1_dut", dut_res(), {24'h800000, 24'h800000, 3'b000, 8'd127, 1'b0, 1'b0, 1'b0, 32'h0});
      send(32'h3FC00000, 32'h40400000, 1'b1);
      @(posedge clk);
      #1;
      post("t3_dut", dut_res(), {24'hC00000, 24'h600000, 3'b000, 8'd128, 1'b1, 1'b1, 1'b0, 32'h0});
      send(32'h3F800000, 32'h33800000, 1'b0);
      send(32'h3F800000, 32'h33000000, 1'b0);
      send(32'h7F800000, 32'h7F800000, 1'b1);
      @(posedge clk);
      #1;
      post("t4_dut", dut_res(), {62'h0, 1'b1, 32'h7FC00000});
      send(32'h7F800000, 32'h3F800000, 1'b1);
      repeat (3) @(posedge clk);

      // back-to-back pairs into a stalled consumer
      #1;
      bus.out_ready = 1'b0;
      acc_n = 0;
      k = 0;
      bus.in_valid = 1'b1;
      bus.in_a = pa[0]; bus.in_b = pb[0]; bus.in_sub = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_n++;
            k++;
            if (k < 3) begin bus.in_a = pa[k]; bus.in_b = pb[k]; bus.in_sub = k[0]; end
            else bus.in_valid = 1'b0;
         end
      end
      post("t5_accepted", 96'(acc_n), 96'd2);
      post("t5_in_ready_low", 96'(bus.in_ready), 96'd0);
      bus.out_ready = 1'b1;
      #1;
      post("t5_comb_ready", 96'(bus.in_ready), 96'd1);
      wait_n = 0;
      while (k < 3 && wait_n < 20) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin k++; bus.in_valid = 1'b0; end
         wait_n++;
      end
      post("t5_third_taken", 96'(k), 96'd3);
      repeat (4) @(posedge clk);

      // asynchronous reset with both stages full
      #1;
      bus.out_ready = 1'b0;
      send(pa[0], pb[0], 1'b0);
      send(pa[1], pb[1], 1'b1);
      @(negedge clk);
      post("t6_full_valid", 96'(bus.out_valid), 96'd1);
      post("t6_full_ready", 96'(bus.in_ready), 96'd0);
      #2;
      rst_n = 1'b0;
      #1;
      post("t6_rst_out_valid", 96'(bus.out_valid), 96'd0);
      post("t6_rst_in_ready", 96'(bus.in_ready), 96'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(32'h3FC00000, 32'h40400000, 1'b1);
      post("t6_lat1", 96'(bus.out_valid), 96'd0);
      @(posedge clk);
      #1;
      post("t6_lat2", 96'(bus.out_valid), 96'd1);

      // randomized operands and handshake
      acc = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (!bus.in_valid || acc) begin
            ra = rand_fp();
            rb = rand_fp();
            case ($urandom_range(0, 5))
               0: rb[30:0] = ra[30:0];
               1, 2: if (ra[30:23] != 8'hFF) begin
                  ex = int'(ra[30:23]) + int'($urandom_range(0, 30)) - 15;
                  if (ex < 0) ex = 0;
                  if (ex > 254) ex = 254;
                  rb[30:23] = 8'(ex);
               end
               default: ;
            endcase
            bus.in_valid = ($urandom_range(0, 2) != 0);
            bus.in_a     = ra;
            bus.in_b     = rb;
            bus.in_sub   = 1'($urandom_range(0, 1));
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
      end

      // drain
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      wait_n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && wait_n < 40) begin
         @(negedge clk);
         #1;
         wait_n++;
      end
      post("drain_queue_empty", 96'(exp_q.size()), 96'd0);
      post("drain_out_valid", 96'(bus.out_valid), 96'd0);
      repeat (3) @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
